// File: rtl/priority_write_arbiter.sv
// priority_write_arbiter
//   Registered write arbiter with INPUT_COUNT channels. Each channel owns a
//   1-deep pending slot that captures its data word when req[i] is strobed.
//   Each cycle, at most one pending slot is granted, using either fixed priority
//   (index 0 highest) or round-robin priority. The granted word is moved into a
//   held output register.
//
//   Ports
//     clk       in   system clock, rising edge
//     rst       in   asynchronous, active-high reset
//     en        in   1 enables grants; slots still fill while 0
//     req       in   per-channel write strobe
//     req_data  in   channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//     ovf_clr   in   clears sticky overflow bits (a same-cycle set wins)
//     data_out  out  last granted word; holds while idle
//     wr_valid  out  1-cycle pulse when data_out was updated
//     grant     out  one-hot channel of the last grant, 0 when wr_valid=0
//     pending   out  slot-full flags
//     overflow  out  sticky flag: request dropped because the slot was full
module priority_write_arbiter #(
  parameter int                    INPUT_COUNT = 4,
  parameter int                    DATA_WIDTH  = 8,
  parameter bit                    RR_MODE     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [INPUT_COUNT-1:0]            req,
  input  logic [INPUT_COUNT*DATA_WIDTH-1:0] req_data,
  input  logic                              ovf_clr,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              wr_valid,
  output logic [INPUT_COUNT-1:0]            grant,
  output logic [INPUT_COUNT-1:0]            pending,
  output logic [INPUT_COUNT-1:0]            overflow
);

  localparam int               PTR_W    = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(INPUT_COUNT - 1);

  logic [DATA_WIDTH-1:0]  slot_data [INPUT_COUNT];
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       sel;
  logic [PTR_W-1:0]       scan_idx;
  logic                   found;
  logic                   grant_valid;
  logic [INPUT_COUNT-1:0] grant_now;
  logic [INPUT_COUNT-1:0] load;
  logic [INPUT_COUNT-1:0] ovf_set;
  int                     scan_int;

  // Winner selection from the registered pending flags only. A word loaded at
  // this edge is therefore never granted at the same edge.
  // The round-robin scan wraps explicitly, so non-power-of-2 counts never
  // index past the last channel.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_int = 0;
    scan_idx = '0;
    if (RR_MODE) begin
      for (int k = 0; k < INPUT_COUNT; k++) begin
        scan_int = int'(rr_ptr) + k;
        if (scan_int >= INPUT_COUNT) scan_int = scan_int - INPUT_COUNT;
        scan_idx = PTR_W'(scan_int);
        if (!found && pending[scan_idx]) begin
          sel   = scan_idx;
          found = 1'b1;
        end
      end
    end else begin
      // Scanning downwards means the lowest pending index is the last one written.
      for (int k = INPUT_COUNT - 1; k >= 0; k--) begin
        if (pending[k]) begin
          sel   = PTR_W'(k);
          found = 1'b1;
        end
      end
    end
  end

  // A slot accepts a new word if it is empty, or if it is being emptied by a
  // grant at this same edge (a refill). Otherwise the word is dropped and the
  // drop is flagged.
  always_comb begin
    grant_valid = en & found;
    grant_now   = '0;
    if (grant_valid) grant_now[sel] = 1'b1;
    load    = req & (~pending | grant_now);
    ovf_set = req & pending & ~grant_now;
  end

  // Slot storage, pending flags and sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
      for (int i = 0; i < INPUT_COUNT; i++) slot_data[i] <= '0;
    end else begin
      pending  <= (pending & ~grant_now) | req;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
      for (int i = 0; i < INPUT_COUNT; i++) begin
        if (load[i]) slot_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register and round-robin pointer. The pointer advances past the
  // winner in both modes; fixed mode simply ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= RESET_VALUE;
      wr_valid <= 1'b0;
      grant    <= '0;
      rr_ptr   <= '0;
    end else if (grant_valid) begin
      data_out <= slot_data[sel];
      wr_valid <= 1'b1;
      grant    <= grant_now;
      rr_ptr   <= (sel == LAST_IDX) ? '0 : sel + PTR_W'(1);
    end else begin
      wr_valid <= 1'b0;
      grant    <= '0;
    end
  end

endmodule

// File: tb/tb_priority_write_arbiter.sv
// tb_priority_write_arbiter
//   Directed bench for priority_write_arbiter. Two instances share all inputs:
//   a fixed-priority one (u_fix, RESET_VALUE=8'hC3) and a round-robin one
//   (u_rr, RESET_VALUE=0). Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, so every check observes the result
//   of the most recent edge.
module tb_priority_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        ovf_clr;

  logic [7:0] f_data_out, r_data_out;
  logic       f_wr_valid, r_wr_valid;
  logic [3:0] f_grant, r_grant;
  logic [3:0] f_pending, r_pending;
  logic [3:0] f_overflow, r_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  priority_write_arbiter #(
    .INPUT_COUNT(4), .DATA_WIDTH(8), .RR_MODE(1'b0), .RESET_VALUE(8'hC3)
  ) u_fix (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .ovf_clr(ovf_clr), .data_out(f_data_out), .wr_valid(f_wr_valid),
    .grant(f_grant), .pending(f_pending), .overflow(f_overflow)
  );

  priority_write_arbiter #(
    .INPUT_COUNT(4), .DATA_WIDTH(8), .RR_MODE(1'b1), .RESET_VALUE(8'h00)
  ) u_rr (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .ovf_clr(ovf_clr), .data_out(r_data_out), .wr_valid(r_wr_valid),
    .grant(r_grant), .pending(r_pending), .overflow(r_overflow)
  );

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, observed, expected);
    end
  endtask

  // Advances past the next rising edge, to the point where inputs are driven
  // and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the request strobe and the four channel words {ch3,ch2,ch1,ch0}.
  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] d3,
                               input logic [7:0] d2, input logic [7:0] d1,
                               input logic [7:0] d0);
    req      = r;
    req_data = {d3, d2, d1, d0};
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ovf_clr = 1'b0;
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

    // T1 reset
    tick(); tick();
    checkOutput("t1_fix_data",  32'(f_data_out), 32'hC3);
    checkOutput("t1_rr_data",   32'(r_data_out), 32'h00);
    checkOutput("t1_wr_valid",  32'(f_wr_valid), 32'h0);
    checkOutput("t1_grant",     32'(f_grant),    32'h0);
    checkOutput("t1_pending",   32'(f_pending),  32'h0);
    checkOutput("t1_overflow",  32'(f_overflow), 32'h0);
    rst = 1'b0;
    tick();

    // T2 fixed priority: ch1 and ch3 together
    en = 1'b1;
    applyStimulus(4'b1010, 8'hB3, 8'h00, 8'hA1, 8'h00);
    tick();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t2_load_pending", 32'(f_pending),  32'hA);
    checkOutput("t2_load_noval",   32'(f_wr_valid), 32'h0);
    tick();
    checkOutput("t2_g1_data",    32'(f_data_out), 32'hA1);
    checkOutput("t2_g1_grant",   32'(f_grant),    32'h2);
    checkOutput("t2_g1_valid",   32'(f_wr_valid), 32'h1);
    checkOutput("t2_g1_pending", 32'(f_pending),  32'h8);
    tick();
    checkOutput("t2_g2_data",  32'(f_data_out), 32'hB3);
    checkOutput("t2_g2_grant", 32'(f_grant),    32'h8);
    tick();
    checkOutput("t2_idle_valid", 32'(f_wr_valid), 32'h0);
    checkOutput("t2_idle_data",  32'(f_data_out), 32'hB3);
    checkOutput("t2_idle_grant", 32'(f_grant),    32'h0);

    // T3 round robin: all four at once, rr_ptr back at 0 after T2
    applyStimulus(4'b1111, 8'h13, 8'h12, 8'h11, 8'h10);
    tick();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("t3_rr0_grant", 32'(r_grant),    32'h1);
    checkOutput("t3_rr0_data",  32'(r_data_out), 32'h10);
    tick();
    checkOutput("t3_rr1_grant", 32'(r_grant),    32'h2);
    checkOutput("t3_rr1_data",  32'(r_data_out), 32'h11);
    tick();
    checkOutput("t3_rr2_grant", 32'(r_grant),    32'h4);
    checkOutput("t3_rr2_data",  32'(r_data_out), 32'h12);
    tick();
    checkOutput("t3_rr3_grant", 32'(r_grant),    32'h8);
    checkOutput("t3_rr3_data",  32'(r_data_out), 32'h13);
    tick();
    checkOutput("t3_rr_idle", 32'(r_wr_valid), 32'h0);
    // A single grant of ch1 moves rr_ptr to 2
    applyStimulus(4'b0010, 8'h00, 8'h00, 8'h31, 8'h00);
    tick();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("t3_ptr_grant", 32'(r_grant), 32'h2);
    applyStimulus(4'b0101, 8'h00, 8'h22, 8'h00, 8'h20);
    tick();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("t3_rr_ch2_first", 32'(r_grant),    32'h4);
    checkOutput("t3_rr_ch2_data",  32'(r_data_out), 32'h22);
    checkOutput("t3_fix_ch0_first", 32'(f_grant),   32'h1);
    tick();
    checkOutput("t3_rr_ch0_second", 32'(r_grant),    32'h1);
    checkOutput("t3_rr_ch0_data",   32'(r_data_out), 32'h20);
    tick();

    // T4 overflow with arbitration disabled
    en = 1'b0;
    applyStimulus(4'b0100, 8'h00, 8'h55, 8'h00, 8'h00);
    tick();
    applyStimulus(4'b0100, 8'h00, 8'h66, 8'h00, 8'h00);
    tick();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t4_pending",  32'(f_pending),  32'h4);
    checkOutput("t4_overflow", 32'(f_overflow), 32'h4);
    checkOutput("t4_no_grant", 32'(f_wr_valid), 32'h0);
    tick();
    checkOutput("t4_en0_hold", 32'(f_pending), 32'h4);
    en = 1'b1;
    tick();
    checkOutput("t4_data",  32'(f_data_out), 32'h55);
    checkOutput("t4_grant", 32'(f_grant),    32'h4);
    checkOutput("t4_drained", 32'(f_pending), 32'h0);
    checkOutput("t4_ovf_sticky", 32'(f_overflow), 32'h4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("t4_ovf_clr", 32'(f_overflow), 32'h0);
    tick();

    // T5 refill of ch0 on the edge it is granted
    applyStimulus(4'b0001, 8'h00, 8'h00, 8'h00, 8'h01);
    tick();
    applyStimulus(4'b0001, 8'h00, 8'h00, 8'h00, 8'h02);
    tick();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t5_first_data",   32'(f_data_out), 32'h01);
    checkOutput("t5_refill_pend",  32'(f_pending),  32'h1);
    checkOutput("t5_refill_noovf", 32'(f_overflow), 32'h0);
    tick();
    checkOutput("t5_second_data", 32'(f_data_out), 32'h02);
    checkOutput("t5_second_valid", 32'(f_wr_valid), 32'h1);
    checkOutput("t5_empty",       32'(f_pending),  32'h0);
    checkOutput("t5_overflow",    32'(f_overflow), 32'h0);
    tick();

    // T6 reset with three slots pending
    en = 1'b0;
    applyStimulus(4'b0111, 8'h00, 8'h77, 8'h76, 8'h75);
    tick();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("t6_pending_before", 32'(f_pending), 32'h7);
    rst = 1'b1;
    #2;
    checkOutput("t6_async_clear", 32'(f_pending),  32'h0);
    checkOutput("t6_async_data",  32'(f_data_out), 32'hC3);
    tick();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_no_pulse_fix", 32'(f_wr_valid), 32'h0);
      checkOutput("t6_no_pulse_rr",  32'(r_wr_valid), 32'h0);
    end
    checkOutput("t6_data_reset", 32'(f_data_out), 32'hC3);
    checkOutput("t6_pending",    32'(r_pending),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
